// File: rtl/soc_design_range_read_master.sv
// Avalon-MM range read master: reads [start_addr, end_addr) word by word
// and streams the responses out, in address order, through a response FIFO.
module soc_design_range_read_master #(
  parameter int DATA_W      = 32,
  parameter int MAX_PENDING = 4,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       start_addr,
  input  logic [31:0]       end_addr,
  output logic              busy,
  output logic              done,
  output logic [31:0]       avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid,
  output logic [DATA_W-1:0] st_data,
  output logic              st_valid,
  input  logic              st_ready
);

  localparam int PW = $clog2(MAX_PENDING + 1);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  localparam logic [31:0] WMASK = 32'hFFFF_FFFC;

  logic [1:0]        state;
  logic [31:0]       cur;
  logic [31:0]       end_q;
  logic [PW-1:0]     pending;
  logic [CW-1:0]     count;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              done_q;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];

  logic [31:0] s_aligned;
  logic [31:0] e_aligned;
  logic [31:0] credit_sum;
  logic [31:0] cur_nxt;
  logic        pend_ok;
  logic        credit_ok;
  logic        rd_req;
  logic        accept;
  logic        push;
  logic        pop;
  logic        fifo_empty;

  assign s_aligned  = start_addr & WMASK;
  assign e_aligned  = end_addr & WMASK;
  assign cur_nxt    = cur + 32'd4;
  assign fifo_empty = (count == '0);

  // Credit counts reads in flight plus words already buffered, so every
  // issued read is guaranteed a FIFO slot when its response returns.
  assign credit_sum = 32'(pending) + 32'(count);
  assign pend_ok    = 32'(pending) < 32'(MAX_PENDING);
  assign credit_ok  = credit_sum < 32'(FIFO_DEPTH);

  assign rd_req = (state == S_READ) && (cur < end_q)
               && pend_ok && credit_ok;
  assign accept = rd_req && !avm_waitrequest;
  assign push   = avm_readdatavalid && (pending != '0);
  assign pop    = !fifo_empty && st_ready;

  assign avm_read    = rd_req;
  assign avm_address = cur;
  assign busy        = (state != S_IDLE);
  assign done        = done_q;
  assign st_valid    = !fifo_empty;
  assign st_data     = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      cur    <= '0;
      end_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state == S_FIN);
      unique case (state)
        S_IDLE: begin
          if (start) begin
            cur   <= s_aligned;
            end_q <= e_aligned;
            if (e_aligned <= s_aligned) begin
              state <= S_FIN;
            end else begin
              state <= S_READ;
            end
          end
        end
        S_READ: begin
          if (accept) begin
            cur <= cur_nxt;
            if (cur_nxt == end_q) begin
              state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if ((pending == '0) && fifo_empty) begin
            state <= S_FIN;
          end
        end
        S_FIN: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
    end else begin
      unique case ({accept, push})
        2'b10:   pending <= pending + 1'b1;
        2'b01:   pending <= pending - 1'b1;
        default: pending <= pending;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: st_valid masks the head until it is written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= avm_readdata;
    end
  end

endmodule
